// File: rtl/instr_fetch_unit_pkg.sv
// Shared types for the RV32I fetch stage: FSM states, buffer entry layout.
// Optional misaligned-redirect trap: IFETCH_MISALIGN_TRAP_EN.
package instr_fetch_unit_pkg;

    localparam logic [31:0] FETCH_RESET_VECTOR = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH_BOOT = 2'd0,
        FETCH_RUN  = 2'd1,
        FETCH_HALT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_unit_fetch_buffer.sv
// In-order instruction buffer holding {pc, instr} pairs for the decoder.
// Flush wins over push and pop in the same cycle.
module instr_fetch_unit_fetch_buffer
    import instr_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int OW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  fetch_entry_t  din,
    output logic [OW-1:0] occ,
    output fetch_entry_t  head
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [OW-1:0] occ_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            occ_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            occ_q <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= din;
                wptr      <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            occ_q <= occ_q + OW'(push) - OW'(pop);
        end
    end

    assign occ  = occ_q;
    assign head = mem[rptr];

    always @(posedge clk) begin
        if (rst_n && !flush) begin
            assert (!(push && !pop && occ_q == OW'(DEPTH)));
            assert (!(pop && occ_q == '0));
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// RV32I fetch stage: PC, imem request issue, stale-response tracking, decoder link.
// Define IFETCH_MISALIGN_TRAP_EN to trap and halt on misaligned redirect targets.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR    = FETCH_RESET_VECTOR,
    parameter int          BUF_DEPTH       = 2,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        fetch_trap
);

    localparam int OW = $clog2(BUF_DEPTH + 1);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int SW = 8;

    fetch_state_e  state_q;
    fetch_state_e  state_d;
    logic [31:0]   pc_q;
    logic [31:0]   rsp_pc_q;
    logic [CW-1:0] outst_q;
    logic [CW-1:0] outst_d;
    logic [CW-1:0] stale_q;
    logic [OW-1:0] occ;
    fetch_entry_t  head;
    fetch_entry_t  din;
    logic          run;
    logic          redir;
    logic          mis;
    logic          space_ok;
    logic          accept;
    logic          push;
    logic          pop;

`ifdef IFETCH_MISALIGN_TRAP_EN
    assign mis = run && redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
    assign mis = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        run     = 1'b0;
        unique case (state_q)
            FETCH_BOOT: state_d = FETCH_RUN;
            FETCH_RUN: begin
                run = 1'b1;
                if (mis) begin
                    state_d = FETCH_HALT;
                end
            end
            FETCH_HALT: state_d = FETCH_HALT;
            default:    state_d = FETCH_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Words already owed to the buffer count against its space.
    assign space_ok = (SW'(occ) + SW'(outst_q) - SW'(stale_q))
                      < SW'(BUF_DEPTH);

    assign redir          = run && redirect_valid;
    assign imem_req_valid = run && !redirect_valid && space_ok
                            && (outst_q < CW'(MAX_OUTSTANDING));
    assign imem_req_addr  = run ? pc_q : '0;
    assign accept         = imem_req_valid && imem_req_ready;
    assign outst_d        = outst_q + CW'(accept) - CW'(imem_rsp_valid);

    assign push = imem_rsp_valid && (stale_q == '0) && !redir;
    assign din  = '{pc: rsp_pc_q, instr: imem_rsp_data};

    assign instr_valid = (occ != '0) && !redirect_valid;
    assign pop         = instr_valid && instr_ready;
    assign instr       = head.instr;
    assign instr_pc    = head.pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RESET_VECTOR;
            rsp_pc_q <= RESET_VECTOR;
            outst_q  <= '0;
            stale_q  <= '0;
        end else begin
            outst_q <= outst_d;
            if (redir) begin
                stale_q  <= outst_d;
                pc_q     <= word_align(redirect_pc);
                rsp_pc_q <= word_align(redirect_pc);
            end else begin
                if (imem_rsp_valid && stale_q != '0) begin
                    stale_q <= stale_q - CW'(1);
                end
                if (accept) begin
                    pc_q <= pc_q + 32'd4;
                end
                if (push) begin
                    rsp_pc_q <= rsp_pc_q + 32'd4;
                end
            end
        end
    end

`ifdef IFETCH_MISALIGN_TRAP_EN
    logic trap_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trap_q <= 1'b0;
        end else if (mis) begin
            trap_q <= 1'b1;
        end
    end

    assign fetch_trap = trap_q;
`else
    assign fetch_trap = 1'b0;
`endif

    instr_fetch_unit_fetch_buffer #(
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redir),
        .din   (din),
        .occ   (occ),
        .head  (head)
    );

    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(imem_rsp_valid && outst_q == '0));
            assert (outst_q <= CW'(MAX_OUTSTANDING));
            assert (stale_q <= outst_q);
        end
    end

endmodule
